quad_step_decoder: RTL

Front-end stage that converts a two-channel quadrature (A/B) position signal into the count-enable and direction controls of the up/down counter. Asynchronous A/B inputs are synchronized, glitch-filtered per channel and decoded by a phase-tracking state machine. Each legal quadrature step produces a single-cycle `o_en` pulse with a matching `o_up_down` level, wired directly to the counter's `i_en` / `i_up_down`.

---
 rtl/quad_pkg.sv | 42 ++++
 rtl/quad_chan_filter.sv | 46 ++++
 rtl/quad_step_decoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder.
// Contents:
//   PH_00/PH_10/PH_11/PH_01 : phase encodings of {a_f,b_f}
//   DIR_UP/DIR_DOWN         : o_up_down levels
//   state_t                 : decoder FSM states (INIT, TRACK)
//   step_up/step_down       : neighbouring phase in each direction
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {INIT, TRACK} state_t;

  // A leads B: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] step_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] step_down(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One quadrature channel: two-flop synchronizer followed by a glitch filter.
// The filtered value only follows the synchronized input after it has
// differed for FILT_CYC consecutive clocks.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   raw  : channel input, asynchronous to clk
//   filt : filtered, synchronized channel level
module quad_chan_filter #(
  parameter int FILT_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_CYC - 1);

  logic       sync_1;
  logic       sync_2;
  logic [3:0] cnt;

  // The counter measures how long sync_2 has disagreed with filt; any
  // agreement restarts it, so short pulses never reach filt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= 4'd0;
      filt   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == filt) begin
        cnt <= 4'd0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync_2;
        cnt  <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end for an up/down counter. Filters both channels,
// tracks the phase and emits one o_en pulse per legal step together with
// its direction. Simultaneous changes of both channels flag o_err.
// Ports:
//   i_clk, i_rst : clock (rising edge), asynchronous active-high reset
//   i_enable     : when low, steps are tracked but not reported
//   i_a, i_b     : asynchronous quadrature channels
//   i_err_clr    : synchronous clear of o_err
//   o_en         : one-cycle step pulse (counter i_en)
//   o_up_down    : direction of last step, 1 = up (counter i_up_down)
//   o_err        : sticky illegal-transition flag
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_CYC = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_a,
  input  logic i_b,
  input  logic i_err_clr,
  output logic o_en,
  output logic o_up_down,
  output logic o_err
);

  // Startup lasts FILT_CYC+3 clocks so the filters have settled on the
  // current input level before the phase is loaded.
  localparam logic [4:0] INIT_LAST = 5'(FILT_CYC + 2);

  logic       a_f;
  logic       b_f;
  logic [1:0] cur;
  state_t     state, state_n;
  logic [1:0] phase, phase_n;
  logic [4:0] init_cnt, init_cnt_n;
  logic       en_n, up_n, err_n;

  quad_chan_filter #(.FILT_CYC(FILT_CYC)) u_filt_a (
    .clk  (i_clk),
    .rst  (i_rst),
    .raw  (i_a),
    .filt (a_f)
  );

  quad_chan_filter #(.FILT_CYC(FILT_CYC)) u_filt_b (
    .clk  (i_clk),
    .rst  (i_rst),
    .raw  (i_b),
    .filt (b_f)
  );

  assign cur = {a_f, b_f};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= INIT;
      phase     <= PH_00;
      init_cnt  <= 5'd0;
      o_en      <= 1'b0;
      o_up_down <= DIR_UP;
      o_err     <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      init_cnt  <= init_cnt_n;
      o_en      <= en_n;
      o_up_down <= up_n;
      o_err     <= err_n;
    end
  end

  // Error clear is the default and a detected illegal change overrides it,
  // so a set in the same cycle as a clear wins.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    init_cnt_n = init_cnt;
    en_n       = 1'b0;
    up_n       = o_up_down;
    err_n      = o_err & ~i_err_clr;
    case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_n    = TRACK;
          phase_n    = cur;
          init_cnt_n = 5'd0;
        end else begin
          init_cnt_n = init_cnt + 5'd1;
        end
      end
      default: begin
        if (cur != phase) begin
          phase_n = cur;
          if (cur == step_up(phase)) begin
            up_n = DIR_UP;
            en_n = i_enable;
          end else if (cur == step_down(phase)) begin
            up_n = DIR_DOWN;
            en_n = i_enable;
          end else if (i_enable) begin
            err_n = 1'b1;
          end
        end
      end
    endcase
  end

endmodule
